evm_vote_session_ctrl: RTL and testbench

//  Sequences one voting session per voter against the voter-ID database and the candidate tally.

---
 rtl/evm_vote_session_ctrl.sv | 159 +++++++++++++++
 tb/tb_evm_vote_session_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/evm_vote_session_ctrl.sv
// Voter session sequencer: ID check, database lookup, one vote, commit.
// Ports: clk/reset, mode, id_valid/voter_id, candidate_btn, db_match in;
//        db_control/db_read/db_write, db_valid_voter, db_address,
//        vote_inc, vote_ok/vote_rej, reject_code, db_full, busy,
//        voter_count out. All outputs registered or decoded from registers.
module evm_vote_session_ctrl #(
    parameter int WORD_SIZE      = 5,
    parameter int ADDRESS_SIZE   = 4,
    parameter int NUM_CANDIDATES = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      id_valid,
    input  logic [WORD_SIZE-1:0]      voter_id,
    input  logic [NUM_CANDIDATES-1:0] candidate_btn,
    input  logic                      db_match,
    output logic                      db_control,
    output logic                      db_read,
    output logic                      db_write,
    output logic [WORD_SIZE-1:0]      db_valid_voter,
    output logic [ADDRESS_SIZE-1:0]   db_address,
    output logic [NUM_CANDIDATES-1:0] vote_inc,
    output logic                      vote_ok,
    output logic                      vote_rej,
    output logic [1:0]                reject_code,
    output logic                      db_full,
    output logic                      busy,
    output logic [ADDRESS_SIZE-1:0]   voter_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDRESS_SIZE-1:0] MAX_COUNT = '1;
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RC_TIMEOUT = 2'b00;
    localparam logic [1:0] RC_ZERO_ID = 2'b01;
    localparam logic [1:0] RC_VOTED   = 2'b10;
    localparam logic [1:0] RC_FULL    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        VOTE,
        COMMIT,
        DONE,
        REJECT
    } state_t;

    state_t                 state;
    state_t                 nxt;
    logic [1:0]             code_n;
    logic [WORD_SIZE-1:0]   id_q;
    logic [TW-1:0]          timer;
    logic                   btn_one;

    // Exactly one button pressed: non-zero and no second bit set.
    assign btn_one = (candidate_btn != '0) &&
                     ((candidate_btn & (candidate_btn - NUM_CANDIDATES'(1))) == '0);

    assign db_full = (voter_count == MAX_COUNT);

    always_comb begin
        nxt    = state;
        code_n = reject_code;
        unique case (state)
            IDLE: begin
                if (id_valid && mode) begin
                    if (voter_id == '0) begin
                        nxt    = REJECT;
                        code_n = RC_ZERO_ID;
                    end else if (db_full) begin
                        nxt    = REJECT;
                        code_n = RC_FULL;
                    end else begin
                        nxt = LOOKUP;
                    end
                end
            end
            LOOKUP: nxt = mode ? CHECK : IDLE;
            CHECK: begin
                if (!mode) begin
                    nxt = IDLE;
                end else if (db_match) begin
                    nxt    = REJECT;
                    code_n = RC_VOTED;
                end else begin
                    nxt = VOTE;
                end
            end
            VOTE: begin
                // A valid press on the last timer tick still wins.
                if (!mode) begin
                    nxt = IDLE;
                end else if (btn_one) begin
                    nxt = COMMIT;
                end else if (timer == LAST_TICK) begin
                    nxt    = REJECT;
                    code_n = RC_TIMEOUT;
                end
            end
            COMMIT: nxt = mode ? DONE : IDLE;
            DONE:   nxt = IDLE;
            REJECT: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are loaded from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            id_q           <= '0;
            timer          <= '0;
            db_control     <= 1'b0;
            db_read        <= 1'b0;
            db_write       <= 1'b0;
            db_valid_voter <= '0;
            db_address     <= '0;
            vote_inc       <= '0;
            vote_ok        <= 1'b0;
            vote_rej       <= 1'b0;
            reject_code    <= '0;
            busy           <= 1'b0;
            voter_count    <= '0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != IDLE);
            db_control <= (nxt == LOOKUP) || (nxt == CHECK) || (nxt == COMMIT);
            db_read    <= (nxt == LOOKUP);
            db_write   <= (nxt == COMMIT);
            vote_ok    <= (nxt == DONE);
            vote_rej   <= (nxt == REJECT);
            vote_inc   <= (nxt == COMMIT) ? candidate_btn : '0;

            if (nxt == REJECT)
                reject_code <= code_n;

            if (state == IDLE && id_valid && mode)
                id_q <= voter_id;

            if (state == VOTE)
                timer <= timer + TW'(1);
            else
                timer <= '0;

            if (nxt == COMMIT) begin
                db_valid_voter <= id_q;
                db_address     <= voter_count;
            end

            if (state == COMMIT && nxt == DONE && voter_count != MAX_COUNT)
                voter_count <= voter_count + ADDRESS_SIZE'(1);
        end
    end

endmodule

// File: tb/tb_evm_vote_session_ctrl.sv
// Directed bench for evm_vote_session_ctrl.
// Drives sessions one cycle at a time and checks against hand values.
module tb_evm_vote_session_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] voter_id = '0;
    logic [3:0] candidate_btn = '0;
    logic       db_match = 1'b0;
    logic       db_control;
    logic       db_read;
    logic       db_write;
    logic [4:0] db_valid_voter;
    logic [3:0] db_address;
    logic [3:0] vote_inc;
    logic       vote_ok;
    logic       vote_rej;
    logic [1:0] reject_code;
    logic       db_full;
    logic       busy;
    logic [3:0] voter_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    evm_vote_session_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .id_valid       (id_valid),
        .voter_id       (voter_id),
        .candidate_btn  (candidate_btn),
        .db_match       (db_match),
        .db_control     (db_control),
        .db_read        (db_read),
        .db_write       (db_write),
        .db_valid_voter (db_valid_voter),
        .db_address     (db_address),
        .vote_inc       (vote_inc),
        .vote_ok        (vote_ok),
        .vote_rej       (vote_rej),
        .reject_code    (reject_code),
        .db_full        (db_full),
        .busy           (busy),
        .voter_count    (voter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // id_valid in cycle 0; returns in cycle 1.
    task automatic start(input logic [4:0] id);
        mode     = 1'b1;
        voter_id = id;
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
    endtask

    task automatic full_vote(input logic [4:0] id, input logic [3:0] btn);
        start(id);
        tick();
        candidate_btn = btn;
        tick();
        tick();
        check("fv_write", {31'd0, db_write}, 1);
        check("fv_addr", {28'd0, db_address}, exp_count);
        candidate_btn = '0;
        tick();
        check("fv_ok", {31'd0, vote_ok}, 1);
        exp_count++;
        tick();
    endtask

    initial begin
        int n;
        logic wr_seen;

        #12;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_cnt", {28'd0, voter_count}, 0);
        check("rst_code", {30'd0, reject_code}, 0);
        reset = 1'b1;
        tick();

        // Normal vote: ID 5, button 0010.
        start(5'd5);
        check("lk_ctrl", {31'd0, db_control}, 1);
        check("lk_read", {31'd0, db_read}, 1);
        check("lk_busy", {31'd0, busy}, 1);
        tick();
        check("ck_ctrl", {31'd0, db_control}, 1);
        check("ck_read", {31'd0, db_read}, 0);
        candidate_btn = 4'b0010;
        tick();
        check("vt_ctrl", {31'd0, db_control}, 0);
        tick();
        check("cm_write", {31'd0, db_write}, 1);
        check("cm_ctrl", {31'd0, db_control}, 1);
        check("cm_id", {27'd0, db_valid_voter}, 5);
        check("cm_addr", {28'd0, db_address}, 0);
        check("cm_inc", {28'd0, vote_inc}, 4'b0010);
        candidate_btn = '0;
        tick();
        check("dn_ok", {31'd0, vote_ok}, 1);
        check("dn_inc", {28'd0, vote_inc}, 0);
        check("dn_cnt", {28'd0, voter_count}, 1);
        exp_count = 1;
        tick();
        check("id_busy", {31'd0, busy}, 0);
        check("id_ok", {31'd0, vote_ok}, 0);
        check("hold_id", {27'd0, db_valid_voter}, 5);

        // Already voted.
        start(5'd5);
        tick();
        db_match = 1'b1;
        tick();
        db_match = 1'b0;
        check("av_rej", {31'd0, vote_rej}, 1);
        check("av_code", {30'd0, reject_code}, 2'b10);
        check("av_write", {31'd0, db_write}, 0);
        check("av_cnt", {28'd0, voter_count}, 1);
        tick();
        check("av_rej_off", {31'd0, vote_rej}, 0);
        check("av_code_hold", {30'd0, reject_code}, 2'b10);

        // Zero ID.
        start(5'd0);
        check("z_rej", {31'd0, vote_rej}, 1);
        check("z_code", {30'd0, reject_code}, 2'b01);
        check("z_read", {31'd0, db_read}, 0);
        tick();

        // Timeout: 0110 (ignored) for 2 cycles then nothing.
        start(5'd7);
        tick();
        tick();
        candidate_btn = 4'b0110;
        n = 0;
        wr_seen = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            n++;
            if (i == 2) candidate_btn = '0;
            if (db_write) wr_seen = 1'b1;
            if (vote_rej) break;
        end
        check("to_cycles", n, 255);
        check("to_code", {30'd0, reject_code}, 2'b00);
        check("to_write", {31'd0, wr_seen}, 0);
        check("to_cnt", {28'd0, voter_count}, 1);
        tick();

        // Abort with mode=0 in VOTE.
        start(5'd9);
        tick();
        tick();
        mode = 1'b0;
        tick();
        check("ab_busy", {31'd0, busy}, 0);
        check("ab_ok", {31'd0, vote_ok}, 0);
        check("ab_rej", {31'd0, vote_rej}, 0);
        tick();
        check("ab_cnt", {28'd0, voter_count}, 1);
        mode = 1'b1;

        // Valid press on the last timer cycle wins, then async reset in COMMIT.
        start(5'd8);
        tick();
        tick();
        for (int i = 0; i < 254; i++) tick();
        check("lp_rej", {31'd0, vote_rej}, 0);
        candidate_btn = 4'b0001;
        tick();
        candidate_btn = '0;
        check("lp_write", {31'd0, db_write}, 1);
        check("lp_inc", {28'd0, vote_inc}, 4'b0001);
        check("lp_addr", {28'd0, db_address}, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_write", {31'd0, db_write}, 0);
        check("ar_inc", {28'd0, vote_inc}, 0);
        check("ar_ctrl", {31'd0, db_control}, 0);
        check("ar_busy", {31'd0, busy}, 0);
        check("ar_cnt", {28'd0, voter_count}, 0);
        check("ar_addr", {28'd0, db_address}, 0);
        #1 reset = 1'b1;
        exp_count = 0;
        tick();

        // Fill the database.
        for (int k = 0; k < 15; k++)
            full_vote(5'(10 + k), 4'(1 << (k % 4)));
        check("fl_cnt", {28'd0, voter_count}, 15);
        check("fl_full", {31'd0, db_full}, 1);

        start(5'd30);
        check("fl_rej", {31'd0, vote_rej}, 1);
        check("fl_code", {30'd0, reject_code}, 2'b11);
        check("fl_read", {31'd0, db_read}, 0);
        tick();
        check("fl_cnt2", {28'd0, voter_count}, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
